// File: rtl/operation_encoder_pkg.sv
// Shared definitions for the per-player operation encoder: operation codes,
// game-state codes, scan codes for both players and small meter/key helpers.
package operation_encoder_pkg;

   typedef enum logic [2:0] {
      OP_NIL      = 3'd0,
      OP_FORWARD  = 3'd1,
      OP_BACKWARD = 3'd2,
      OP_LEFT     = 3'd3,
      OP_RIGHT    = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETTING   = 3'd1,
      ST_COUNTDOWN = 3'd3,
      ST_RACING    = 3'd4,
      ST_PAUSE     = 3'd5,
      ST_FINISH    = 3'd6
   } game_state_t;

   localparam int unsigned DIV_W = 20;

   // {E0-extended flag, scan code}
   localparam logic [8:0] P1_KEY_UP    = 9'h01D;
   localparam logic [8:0] P1_KEY_DOWN  = 9'h01B;
   localparam logic [8:0] P1_KEY_LEFT  = 9'h01C;
   localparam logic [8:0] P1_KEY_RIGHT = 9'h023;
   localparam logic [8:0] P1_KEY_BOOST = 9'h012;
   localparam logic [8:0] P2_KEY_UP    = 9'h175;
   localparam logic [8:0] P2_KEY_DOWN  = 9'h172;
   localparam logic [8:0] P2_KEY_LEFT  = 9'h16B;
   localparam logic [8:0] P2_KEY_RIGHT = 9'h174;
   localparam logic [8:0] P2_KEY_BOOST = 9'h059;

   // held[] bit that backs a given direction
   function automatic logic [4:0] dir_mask(input op_t dir);
      logic [4:0] m;
      case (dir)
         OP_FORWARD:  m = 5'b00001;
         OP_BACKWARD: m = 5'b00010;
         OP_LEFT:     m = 5'b00100;
         OP_RIGHT:    m = 5'b01000;
         default:     m = 5'b00000;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] sat_dec(input logic [7:0] lvl);
      return (lvl == 8'd0) ? 8'd0 : lvl - 8'd1;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] lvl, input logic [7:0] max_lvl);
      return (lvl >= max_lvl) ? max_lvl : lvl + 8'd1;
   endfunction

endpackage

// File: rtl/operation_encoder_boost_meter.sv
// Boost meter: drains while boosting and recharges otherwise, using one
// prescaler that restarts whenever the boost request toggles.
module operation_encoder_boost_meter
   import operation_encoder_pkg::*;
#(
   parameter logic [7:0]  BOOST_MAX  = 8'd255,
   parameter int unsigned DRAIN_DIV  = 250_000,
   parameter int unsigned CHARGE_DIV = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic       boost,
   output logic [7:0] level
);

   localparam logic [DIV_W-1:0] DRAIN_LAST  = DIV_W'(DRAIN_DIV - 1);
   localparam logic [DIV_W-1:0] CHARGE_LAST = DIV_W'(CHARGE_DIV - 1);

   game_state_t      state_s;
   logic [DIV_W-1:0] period_last_s;
   logic [DIV_W-1:0] div_cnt_r;
   logic [7:0]       level_r;
   logic             boost_prev_r;

   assign state_s = game_state_t'(state);
   assign level   = level_r;

   // Select the prescaler period for the current mode
   always_comb begin
      period_last_s = CHARGE_LAST;
      if (boost) begin
         period_last_s = DRAIN_LAST;
      end else begin
         period_last_s = CHARGE_LAST;
      end
   end

   // Meter level, prescaler and previous-boost tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         level_r      <= BOOST_MAX;
         div_cnt_r    <= '0;
         boost_prev_r <= 1'b0;
      end else begin
         boost_prev_r <= boost;
         case (state_s)
            ST_IDLE, ST_SETTING, ST_COUNTDOWN: begin
               level_r   <= BOOST_MAX;
               div_cnt_r <= '0;
            end
            ST_RACING: begin
               // A mode change restarts the period so partial counts never carry over
               if (boost != boost_prev_r) begin
                  div_cnt_r <= '0;
               end else if (div_cnt_r == period_last_s) begin
                  div_cnt_r <= '0;
                  level_r   <= boost ? sat_dec(level_r) : sat_inc(level_r, BOOST_MAX);
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_W'(1);
               end
            end
            default: begin
               level_r   <= level_r;
               div_cnt_r <= div_cnt_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/operation_encoder.sv
// Per-player keyboard front end: tracks held direction/boost keys from PS/2
// events, resolves them to one operation and gates boost through the meter.
module operation_encoder
   import operation_encoder_pkg::*;
#(
   parameter logic [8:0]  KEY_UP     = P1_KEY_UP,
   parameter logic [8:0]  KEY_DOWN   = P1_KEY_DOWN,
   parameter logic [8:0]  KEY_LEFT   = P1_KEY_LEFT,
   parameter logic [8:0]  KEY_RIGHT  = P1_KEY_RIGHT,
   parameter logic [8:0]  KEY_BOOST  = P1_KEY_BOOST,
   parameter logic [7:0]  BOOST_MAX  = 8'd255,
   parameter int unsigned DRAIN_DIV  = 250_000,
   parameter int unsigned CHARGE_DIV = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic       key_valid,
   input  logic [8:0] key_code,
   input  logic       key_break,
   output logic [2:0] operation_code,
   output logic       boost,
   output logic [7:0] boost_level
);

   logic [4:0] match_s;
   op_t        match_dir_s;
   op_t        resolved_s;
   logic       racing_s;
   logic [4:0] held_r;
   op_t        last_dir_r;
   op_t        op_r;
   logic       boost_r;

   assign racing_s       = (state == ST_RACING);
   assign operation_code = op_r;
   assign boost          = boost_r;

   // Decode the incoming scan code against this player's key map
   always_comb begin
      match_s     = 5'b00000;
      match_s[0]  = (key_code == KEY_UP);
      match_s[1]  = (key_code == KEY_DOWN);
      match_s[2]  = (key_code == KEY_LEFT);
      match_s[3]  = (key_code == KEY_RIGHT);
      match_s[4]  = (key_code == KEY_BOOST);
      match_dir_s = OP_NIL;
      if (match_s[0]) begin
         match_dir_s = OP_FORWARD;
      end else if (match_s[1]) begin
         match_dir_s = OP_BACKWARD;
      end else if (match_s[2]) begin
         match_dir_s = OP_LEFT;
      end else if (match_s[3]) begin
         match_dir_s = OP_RIGHT;
      end else begin
         match_dir_s = OP_NIL;
      end
   end

   // Held-key set and most-recent direction; repeats of a held key keep last_dir
   always_ff @(posedge clk) begin
      if (rst) begin
         held_r     <= 5'b00000;
         last_dir_r <= OP_NIL;
      end else if (key_valid && (match_s != 5'b00000)) begin
         if (!key_break) begin
            held_r <= held_r | match_s;
            if ((match_dir_s != OP_NIL) && ((held_r & match_s) == 5'b00000)) begin
               last_dir_r <= match_dir_s;
            end
         end else begin
            held_r <= held_r & ~match_s;
            if ((match_dir_s != OP_NIL) && (match_dir_s == last_dir_r)) begin
               last_dir_r <= OP_NIL;
            end
         end
      end
   end

   // Last-pressed direction wins, otherwise fixed priority among held keys
   always_comb begin
      resolved_s = OP_NIL;
      if ((last_dir_r != OP_NIL) && ((held_r & dir_mask(last_dir_r)) != 5'b00000)) begin
         resolved_s = last_dir_r;
      end else if (held_r[0]) begin
         resolved_s = OP_FORWARD;
      end else if (held_r[1]) begin
         resolved_s = OP_BACKWARD;
      end else if (held_r[2]) begin
         resolved_s = OP_LEFT;
      end else if (held_r[3]) begin
         resolved_s = OP_RIGHT;
      end else begin
         resolved_s = OP_NIL;
      end
   end

   // Registered outputs, only live while racing
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r    <= OP_NIL;
         boost_r <= 1'b0;
      end else begin
         op_r    <= racing_s ? resolved_s : OP_NIL;
         boost_r <= racing_s && held_r[4] && (resolved_s != OP_NIL) && (boost_level != 8'd0);
      end
   end

   operation_encoder_boost_meter #(
      .BOOST_MAX  (BOOST_MAX),
      .DRAIN_DIV  (DRAIN_DIV),
      .CHARGE_DIV (CHARGE_DIV)
   ) u_boost_meter (
      .clk   (clk),
      .rst   (rst),
      .state (state),
      .boost (boost_r),
      .level (boost_level)
   );

endmodule

// File: tb/tb_operation_encoder.sv
// Scoreboard bench for operation_encoder: a cycle-level reference model pushes
// expected outputs each edge, a negedge monitor pops and compares them.
module tb_operation_encoder;

   localparam int DRAIN  = 4;
   localparam int CHARGE = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_break;
   logic [2:0] operation_code;
   logic       boost;
   logic [7:0] boost_level;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int op;
      int bst;
      int lvl;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   operation_encoder #(
      .DRAIN_DIV  (DRAIN),
      .CHARGE_DIV (CHARGE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .state          (state),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .key_break      (key_break),
      .operation_code (operation_code),
      .boost          (boost),
      .boost_level    (boost_level)
   );

   // ---------------- reference model ----------------
   bit m_held[5];   // 0 up, 1 down, 2 left, 3 right, 4 boost
   int m_last;      // 0 none, else operation code of last newly pressed direction
   int m_op, m_boost, m_level, m_cnt, m_prev;

   function automatic int key_role(input logic [8:0] c);
      case (c)
         9'h01D:  return 0;
         9'h01B:  return 1;
         9'h01C:  return 2;
         9'h023:  return 3;
         9'h012:  return 4;
         default: return -1;
      endcase
   endfunction

   function automatic int resolve();
      if (m_last != 0 && m_held[m_last-1]) return m_last;
      for (int i = 0; i < 4; i++) if (m_held[i]) return i + 1;
      return 0;
   endfunction

   always @(posedge clk) begin : model
      exp_t e;
      int   res, nop, nb, role;
      if (rst) begin
         for (int i = 0; i < 5; i++) m_held[i] = 1'b0;
         m_last = 0; m_op = 0; m_boost = 0; m_level = 255; m_cnt = 0; m_prev = 0;
      end else begin
         res = resolve();
         nop = (state == 3'd4) ? res : 0;
         nb  = (state == 3'd4 && m_held[4] && res != 0 && m_level != 0) ? 1 : 0;
         if (state == 3'd0 || state == 3'd1 || state == 3'd3) begin
            m_level = 255; m_cnt = 0;
         end else if (state == 3'd4) begin
            if (m_boost != m_prev) begin
               m_cnt = 0;
            end else begin
               m_cnt++;
               if (m_cnt == (m_boost != 0 ? DRAIN : CHARGE)) begin
                  m_cnt = 0;
                  if (m_boost != 0) m_level = (m_level > 0) ? m_level - 1 : 0;
                  else              m_level = (m_level < 255) ? m_level + 1 : 255;
               end
            end
         end
         m_prev = m_boost;
         role = key_role(key_code);
         if (key_valid && role >= 0) begin
            if (!key_break) begin
               if (role < 4 && !m_held[role]) m_last = role + 1;
               m_held[role] = 1'b1;
            end else begin
               m_held[role] = 1'b0;
               if (m_last == role + 1) m_last = 0;
            end
         end
         m_op = nop;
         m_boost = nb;
      end
      e.op = m_op; e.bst = m_boost; e.lvl = m_level;
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (operation_code !== 3'(e.op) || boost !== 1'(e.bst) || boost_level !== 8'(e.lvl)) begin
            mismatched++;
            $display("FAIL scoreboard t=%0t got op=%0d boost=%0d level=%0d want op=%0d boost=%0d level=%0d",
                     $time, operation_code, boost, boost_level, e.op, e.bst, e.lvl);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic spot(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [8:0] c, input logic b);
      key_valid = 1'b1; key_code = c; key_break = b;
      tick();
      key_valid = 1'b0; key_code = 9'h000; key_break = 1'b0;
   endtask

   task automatic chk_op(input string name, input int want);
      tick();
      @(negedge clk);
      spot(name, int'(operation_code), want);
   endtask

   logic [8:0] key_tab [6] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h012, 9'h15A};
   int         st_tab  [8] = '{0, 1, 3, 4, 4, 4, 5, 6};

   initial begin
      bit found;
      rst = 1'b1; state = 3'd0; key_valid = 1'b0; key_code = 9'h000; key_break = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      spot("reset_op", int'(operation_code), 0);
      spot("reset_boost", int'(boost), 0);
      spot("reset_level", int'(boost_level), 255);
      rst = 1'b0; state = 3'd4;
      tick();

      // forward press/release
      key(9'h01D, 1'b0); chk_op("s1_forward", 1);
      key(9'h01D, 1'b1); chk_op("s1_release", 0);

      // last-pressed wins, priority fallback, typematic repeat
      key(9'h01D, 1'b0); key(9'h01C, 1'b0); chk_op("s2_last_wins", 3);
      key(9'h01C, 1'b1); chk_op("s2_fallback", 1);
      key(9'h01C, 1'b0); key(9'h01D, 1'b0); chk_op("s2_repeat_fwd", 3);
      key(9'h01B, 1'b0); key(9'h01C, 1'b0); chk_op("s2_repeat_left", 2);
      key(9'h01B, 1'b1); key(9'h01C, 1'b1); chk_op("s2_back_to_fwd", 1);

      // drain four steps, then recharge
      key(9'h012, 1'b0);
      repeat (18) tick();
      @(negedge clk);
      spot("s3_drain_level", int'(boost_level), 251);
      spot("s3_boost_on", int'(boost), 1);
      key(9'h012, 1'b1);
      repeat (10) tick();
      @(negedge clk);
      spot("s3_charge_level", int'(boost_level), 252);
      spot("s3_boost_off", int'(boost), 0);
      repeat (60) tick();
      @(negedge clk);
      spot("s3_cap", int'(boost_level), 255);

      // drain to empty, pause, countdown reload
      key(9'h012, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 1400 && !found; i++) begin
         @(negedge clk);
         if (boost_level == 8'd0) found = 1'b1;
      end
      if (!found) begin
         spot("s4_drain_timeout", 0, 1);
      end else begin
         spot("s4_boost_at_zero", int'(boost), 1);
         @(negedge clk);
         spot("s4_boost_drop", int'(boost), 0);
      end
      repeat (20) tick();
      state = 3'd5;
      repeat (30) tick();
      state = 3'd3;
      tick();
      @(negedge clk);
      spot("s4_countdown_reload", int'(boost_level), 255);

      // not racing forces NIL; entering RACING shows held key without new event
      state = 3'd1;
      key(9'h01D, 1'b1); key(9'h01D, 1'b0); chk_op("s5_setting_nil", 0);
      state = 3'd4;
      tick();
      @(negedge clk);
      spot("s5_racing_fwd", int'(operation_code), 1);

      // unknown code ignored; reset mid-boost
      repeat (5) tick();
      key(9'h15A, 1'b0); key(9'h15A, 1'b1); chk_op("s6_unknown", 1);
      spot("s6_boosting", int'(boost), 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      spot("s6_rst_op", int'(operation_code), 0);
      spot("s6_rst_boost", int'(boost), 0);
      spot("s6_rst_level", int'(boost_level), 255);
      rst = 1'b0;

      // randomized phase, checked by the scoreboard
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         key_valid = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 9) == 0) key_code = 9'($urandom);
         else                           key_code = key_tab[$urandom_range(0, 5)];
         key_break = ($urandom_range(0, 99) < 40);
         if ($urandom_range(0, 99) < 2) state = 3'(st_tab[$urandom_range(0, 7)]);
         rst = ($urandom_range(0, 999) < 3);
      end
      @(negedge clk);
      key_valid = 1'b0; rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
